obi_mem_responder: RTL

OBI_MEM_RESPONDER -- requirements
Module: obi_mem_responder

---
 rtl/obi_pkg.sv | 42 ++++
 rtl/obi_mem_responder_if.sv | 10 +
 rtl/obi_resp_pipe.sv | 37 +++
 rtl/obi_mem_responder.sv | 97 +++++++++
 4 files changed

// File: rtl/obi_pkg.sv
// Shared OBI request/response types, legal parameter bounds for the memory
// responder, and the byte-enable merge helper used on writes.
package obi_pkg;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

    localparam int unsigned NumWordsMin       = 32'd2;
    localparam int unsigned NumWordsMax       = 32'd4096;
    localparam int unsigned LatencyMin        = 32'd1;
    localparam int unsigned LatencyMax        = 32'd4;
    localparam int unsigned MaxOutstandingMin = 32'd1;
    localparam int unsigned MaxOutstandingMax = 32'd8;

    // Replace only the bytes of old_word whose byte-enable bit is set.
    function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/obi_mem_responder_if.sv
// OBI request/response bundle between an initiator and the memory responder.
interface obi_mem_responder_if;

    obi_pkg::obi_req_t  req;
    obi_pkg::obi_resp_t resp;

    modport master (output req, input resp);
    modport slave  (input req, output resp);

endinterface

// File: rtl/obi_resp_pipe.sv
// Fixed-length response delay line: a valid bit plus read data per stage.
// Data is zeroed for empty stages so rdata reads 0 whenever rvalid is low.
module obi_resp_pipe #(
    parameter int unsigned Latency = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_i,
    input  logic [31:0] rdata_i,
    output logic        valid_o,
    output logic [31:0] rdata_o
);

    logic [Latency-1:0] valid_r;
    logic [31:0]        data_r [Latency];

    // Shift responses one stage per cycle; reset drops everything in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_r <= '0;
            for (int i = 0; i < Latency; i++) begin
                data_r[i] <= 32'h0;
            end
        end else begin
            valid_r[0] <= valid_i;
            data_r[0]  <= valid_i ? rdata_i : 32'h0;
            for (int i = 1; i < Latency; i++) begin
                valid_r[i] <= valid_r[i-1];
                data_r[i]  <= data_r[i-1];
            end
        end
    end

    assign valid_o = valid_r[Latency-1];
    assign rdata_o = data_r[Latency-1];

endmodule

// File: rtl/obi_mem_responder.sv
// Single-port OBI word memory with fixed response latency and a bounded
// number of granted-but-unanswered transactions.
module obi_mem_responder
    import obi_pkg::*;
#(
    parameter int unsigned NumWords       = 256,
    parameter int unsigned Latency        = 1,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  obi_req_t  obi_req_i,
    output obi_resp_t obi_resp_o
);

    localparam int unsigned IdxW = $clog2(NumWords);
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    if ((NumWords < NumWordsMin) || (NumWords > NumWordsMax) ||
        ((NumWords & (NumWords - 1)) != 0)) begin : g_bad_numwords
        $error("obi_mem_responder: NumWords must be a power of two in range");
    end
    if ((Latency < LatencyMin) || (Latency > LatencyMax)) begin : g_bad_latency
        $error("obi_mem_responder: Latency out of range");
    end
    if ((MaxOutstanding < MaxOutstandingMin) ||
        (MaxOutstanding > MaxOutstandingMax)) begin : g_bad_maxout
        $error("obi_mem_responder: MaxOutstanding out of range");
    end

    logic [31:0]     mem_r [NumWords];
    logic [IdxW-1:0] idx_s;
    logic [CntW-1:0] count_r;
    logic            gnt_s;
    logic [31:0]     rd_word_s;
    logic            rvalid_s;
    logic [31:0]     rdata_s;
    logic            unused_addr_s;

    assign idx_s         = obi_req_i.addr[IdxW+1:2];
    assign unused_addr_s = ^{obi_req_i.addr[31:IdxW+2], obi_req_i.addr[1:0]};

    // Grant when a slot is free, or when the oldest entry retires this cycle.
    always_comb begin
        gnt_s = 1'b0;
        if (rst_ni && obi_req_i.req &&
            ((count_r < CntW'(MaxOutstanding)) || rvalid_s)) begin
            gnt_s = 1'b1;
        end else begin
            gnt_s = 1'b0;
        end
    end

    // Read word captured into the delay line; writes answer with zero data.
    always_comb begin
        rd_word_s = 32'h0;
        if (obi_req_i.we) begin
            rd_word_s = 32'h0;
        end else begin
            rd_word_s = mem_r[idx_s];
        end
    end

    // Memory array, deliberately without reset.
    always_ff @(posedge clk_i) begin
        if (gnt_s && obi_req_i.we) begin
            mem_r[idx_s] <= be_merge(mem_r[idx_s], obi_req_i.wdata, obi_req_i.be);
        end
    end

    // Outstanding counter: grant adds, rvalid retires, both together hold.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_r <= '0;
        end else begin
            case ({gnt_s, rvalid_s})
                2'b10:   count_r <= count_r + CntW'(1);
                2'b01:   count_r <= count_r - CntW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    obi_resp_pipe #(
        .Latency (Latency)
    ) u_resp_pipe (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (gnt_s),
        .rdata_i (rd_word_s),
        .valid_o (rvalid_s),
        .rdata_o (rdata_s)
    );

    assign obi_resp_o = '{gnt: gnt_s, rvalid: rvalid_s, rdata: rdata_s};

endmodule
